// File: rtl/float_encoder_seq.sv
// Sequential linear-to-floating-point encoder: a shift-and-count normaliser
// followed by round-half-up and exponent saturation, with valid/ready on both sides.
`timescale 1ns/1ps
module float_encoder_seq #(
  parameter int IN_W   = 12,
  parameter int MAN_W  = 4,
  parameter int EXP_W  = 3,
  parameter int SIGNED = 0,
  parameter int ROUND  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SHIFT_MAX = IN_W - MAN_W;
  localparam int CNT_W     = $clog2(SHIFT_MAX + 2);
  localparam int EMAX      = (1 << EXP_W) - 1;

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  sreg_q, sreg_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic             sign_q, sign_d;
  logic             out_sign_q, out_sign_d;
  logic [EXP_W-1:0] out_exp_q, out_exp_d;
  logic [MAN_W-1:0] out_man_q, out_man_d;
  logic             out_sat_q, out_sat_d;
  logic             out_valid_q, out_valid_d;

  logic             neg;
  logic [IN_W-1:0]  mag;
  logic [MAN_W-1:0] man_raw, man_rnd;
  logic [MAN_W:0]   man_inc;
  logic             rbit;
  logic [CNT_W:0]   e_ext;
  logic             sat;

  // Magnitude of the incoming sample; the most-negative value maps to 2^(IN_W-1).
  always_comb begin
    neg = (SIGNED != 0) && in_data[IN_W-1];
    mag = neg ? -in_data : in_data;
  end

  // Rounding/saturation on the normalised register; the exponent is the residual count.
  always_comb begin
    man_raw = sreg_q[IN_W-1 -: MAN_W];
    rbit    = sreg_q[IN_W-MAN_W-1];
    man_inc = {1'b0, man_raw} + (MAN_W+1)'(1);
    man_rnd = man_raw;
    e_ext   = {1'b0, ecnt_q};
    if ((ROUND != 0) && rbit) begin
      if (man_inc[MAN_W]) begin
        man_rnd          = '0;
        man_rnd[MAN_W-1] = 1'b1;
        e_ext            = e_ext + (CNT_W+1)'(1);
      end else begin
        man_rnd = man_inc[MAN_W-1:0];
      end
    end
    sat = int'(e_ext) > EMAX;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    ecnt_d      = ecnt_q;
    sign_d      = sign_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_man_d   = out_man_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d  = neg;
          sreg_d  = mag;
          ecnt_d  = CNT_W'(SHIFT_MAX);
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (sreg_q[IN_W-1] || (ecnt_q == '0)) begin
          state_d = S_ROUND;
        end else begin
          sreg_d = sreg_q << 1;
          ecnt_d = ecnt_q - CNT_W'(1);
        end
      end
      S_ROUND: begin
        out_sign_d  = sign_q;
        out_exp_d   = sat ? EXP_W'(EMAX) : EXP_W'(e_ext);
        out_man_d   = sat ? '1 : man_rnd;
        out_sat_d   = sat;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      ecnt_q      <= '0;
      sign_q      <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_man_q   <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      ecnt_q      <= ecnt_d;
      sign_q      <= sign_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_man_q   <= out_man_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_man   = out_man_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_float_encoder_seq.sv
// Bench for float_encoder_seq: three instances (unsigned/round, signed/round,
// unsigned/truncate) share one input stream and are compared to an arithmetic model.
`timescale 1ns/1ps
module tb_float_encoder_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic       rdy  [3];
  logic       sgn_o[3];
  logic [2:0] exp_o[3];
  logic [3:0] man_o[3];
  logic       sat_o[3];
  logic       ov   [3];

  logic [8:0] cap[3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  float_encoder_seq #(.SIGNED(0), .ROUND(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .out_sign(sgn_o[0]), .out_exp(exp_o[0]), .out_man(man_o[0]), .out_sat(sat_o[0]),
    .out_valid(ov[0]), .out_ready(out_ready));

  float_encoder_seq #(.SIGNED(1), .ROUND(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .out_sign(sgn_o[1]), .out_exp(exp_o[1]), .out_man(man_o[1]), .out_sat(sat_o[1]),
    .out_valid(ov[1]), .out_ready(out_ready));

  float_encoder_seq #(.SIGNED(0), .ROUND(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[2]),
    .out_sign(sgn_o[2]), .out_exp(exp_o[2]), .out_man(man_o[2]), .out_sat(sat_o[2]),
    .out_valid(ov[2]), .out_ready(out_ready));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] res(input int i);
    return {sgn_o[i], exp_o[i], man_o[i], sat_o[i]};
  endfunction

  // Encoding computed from the value itself: leading-one position, integer shifts, clamps.
  function automatic logic [8:0] model(input logic [11:0] x, input bit sgn, input bit rnd,
                                       output int lat);
    int  mag, p, e, m, r;
    bit  s, st;
    s   = sgn && x[11];
    mag = s ? 4096 - int'(x) : int'(x);
    p   = -1;
    for (int i = 0; i < 12; i++) if (mag >= (1 << i)) p = i;
    if (p < 4) begin
      e = 0; m = mag; r = 0;
    end else begin
      e = p - 3; m = mag >> (p - 3); r = (mag >> (p - 4)) & 1;
    end
    if (rnd && r == 1) begin
      m++;
      if (m == 16) begin m = 8; e++; end
    end
    st = 1'b0;
    if (e > 7) begin e = 7; m = 15; st = 1'b1; end
    lat = ((11 - p) < 8 ? (11 - p) : 8) + 2;
    return {s, 3'(e), 4'(m), st};
  endfunction

  // Present one sample to all instances and capture each result and its latency.
  task automatic encode(input logic [11:0] x);
    logic [8:0] exp_r[3];
    int         lat_exp[3];
    int         lat_got[3];
    bit         ok;
    exp_r[0] = model(x, 1'b0, 1'b1, lat_exp[0]);
    exp_r[1] = model(x, 1'b1, 1'b1, lat_exp[1]);
    exp_r[2] = model(x, 1'b0, 1'b0, lat_exp[2]);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = rdy[0] && rdy[1] && rdy[2];
    end
    check($sformatf("ready_wait_%h", x), 32'(ok), 32'd1);
    in_data  = x;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("busy_after_accept_%h", x), {29'd0, rdy[0], rdy[1], rdy[2]}, 32'd0);
    for (int i = 0; i < 3; i++) begin lat_got[i] = 0; cap[i] = 'x; end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (ov[i] && lat_got[i] == 0) begin
          lat_got[i] = k;
          cap[i]     = res(i);
        end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lat%0d_%h", i, x), lat_got[i], lat_exp[i]);
      check($sformatf("res%0d_%h", i, x), 32'(cap[i]), 32'(exp_r[i]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [11:0] x;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_out%0d", i), {22'd0, res(i), ov[i]}, 32'd0);
      check($sformatf("reset_rdy%0d", i), 32'(rdy[i]), 32'd1);
    end
    rst_n = 1'b1;

    encode(12'h1A6); check("dir_1a6", 32'(cap[0]), 32'({1'b0, 3'd5, 4'b1101, 1'b0}));
    encode(12'h00D); check("dir_00d", 32'(cap[0]), 32'({1'b0, 3'd0, 4'b1101, 1'b0}));
    encode(12'h000); check("dir_000", 32'(cap[0]), 32'd0);
    encode(12'h1F8); check("dir_1f8_rnd", 32'(cap[0]), 32'({1'b0, 3'd6, 4'b1000, 1'b0}));
                     check("dir_1f8_trn", 32'(cap[2]), 32'({1'b0, 3'd5, 4'b1111, 1'b0}));
    encode(12'h800); check("dir_800_u", 32'(cap[0]), 32'({1'b0, 3'd7, 4'b1111, 1'b1}));
                     check("dir_800_s", 32'(cap[1]), 32'({1'b1, 3'd7, 4'b1111, 1'b1}));
    encode(12'h7F8); check("dir_7f8", 32'(cap[0]), 32'({1'b0, 3'd7, 4'b1111, 1'b1}));
    encode(12'hE5A); check("dir_e5a_s", 32'(cap[1]), 32'({1'b1, 3'd5, 4'b1101, 1'b0}));
    encode(12'h001); check("dir_001_s", 32'(cap[1]), 32'({1'b0, 3'd0, 4'b0001, 1'b0}));
    encode(12'hFFF);
    encode(12'h00F);
    encode(12'h010);

    // Backpressure: outputs hold and the block stays busy until out_ready.
    out_ready = 1'b0;
    encode(12'h1A6);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("hold_res%0d_c%0d", i, c), 32'(res(i)), 32'(cap[i]));
        check($sformatf("hold_flags%0d_c%0d", i, c), {30'd0, ov[i], rdy[i]}, 32'd2);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release", {26'd0, rdy[0], rdy[1], rdy[2], ov[0], ov[1], ov[2]}, 32'h38);

    // Reset while normalising a long-latency sample.
    in_data = 12'h001; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ov[0] || ov[1] || ov[2]) seen++;
    end
    check("midreset_no_valid", seen, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midreset_out%0d", i), 32'(res(i)), 32'd0);
      check($sformatf("midreset_rdy%0d", i), 32'(rdy[i]), 32'd1);
    end

    for (int n = 0; n < 40; n++) begin
      x = 12'($urandom_range(0, 4095));
      if (n % 2 == 1) x = x >> $urandom_range(0, 11);
      encode(x);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_encoder_seq.md
# float_encoder_seq

Sequential, parametrised linear-to-floating-point encoder for the floating-point converter datapath. It accepts an IN_W-bit sample over a valid/ready handshake and normalises it one bit per cycle with a shift-and-count loop. It then rounds to MAN_W mantissa bits, saturates on exponent overflow, and presents {sign, exponent, mantissa, sat} on a valid/ready output. It generalises the fixed 12-bit / 3-bit-exponent / 4-bit-significand leading-zero extractor by adding:
- configurable widths;
- two's-complement input;
- in-block rounding;
- flow control.

## Interface
Parameters:
- IN_W, 12: input sample width; must satisfy IN_W ≥ MAN_W+2.
- MAN_W, 4: mantissa (significand) width.
- EXP_W, 3: exponent width; EMAX = 2^EXP_W − 1.
- SIGNED, 0: 1 = input is two's complement; 0 = input is unsigned magnitude.
- ROUND, 1: 1 = round-half-up on the first dropped bit; 0 = truncate.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  IN_W  sample to encode.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept; equals (state==IDLE).
- out_sign  out  1  sign of the encoded value.
- out_exp  out  EXP_W  exponent E.
- out_man  out  MAN_W  mantissa M. Encoded value ≈ M·2^E.
- out_sat  out  1  result was clamped to {EMAX, all-ones}.
- out_valid  out  1  outputs are valid.
- out_ready  in  1  downstream accepts the result.

## Operation
Encoding rule (p = index of leading one of the magnitude):
- If p < MAN_W or the magnitude is 0: E = 0, M = mag[MAN_W−1:0]. This case is exact; no rounding.
- Otherwise: E = p−MAN_W+1, M = mag[p:p−MAN_W+1], round bit r = mag[p−MAN_W].
- If ROUND=1 and r=1, then M+1:
  - On mantissa carry-out: M = 1 followed by MAN_W−1 zeros, and E = E+1.
- If E > EMAX: E = EMAX, M = all ones, out_sat = 1.

Magnitude and sign:
- SIGNED=0: sign = 0, mag = in_data.
- SIGNED=1: sign = in_data[IN_W−1], mag = |in_data| as an unsigned IN_W-bit value. The most-negative input gives mag = 2^(IN_W−1) with no wrap.

Internal exponent counter is wide enough to hold IN_W−MAN_W+1 without wrap.

State machine:
- IDLE:
  - in_ready = 1.
  - On in_valid: latch sign, load sreg = mag, set ecnt = IN_W−MAN_W, go to NORM.
- NORM:
  - If sreg[IN_W−1] = 1 or ecnt = 0: go to ROUND.
  - Otherwise: sreg <<= 1 (zero fill), ecnt −= 1, stay in NORM.
- ROUND:
  - M = sreg[IN_W−1 : IN_W−MAN_W], r = sreg[IN_W−MAN_W−1].
  - Apply rounding and saturation, register the outputs, set out_valid = 1, go to DONE.
- DONE:
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - On out_ready: clear out_valid, go to IDLE.

## Timing
- Reset (rst_n=0 at a clk edge):
  - State = IDLE.
  - out_sign, out_exp, out_man, out_sat and out_valid are 0.
  - in_ready is 1 from the first cycle after reset.
- Reset mid-operation (any state): the in-flight sample is discarded; no out_valid is produced for it.
- Latency:
  - Let s = min(IN_W−1−p, IN_W−MAN_W), with s = IN_W−MAN_W for a zero input.
  - out_valid rises s+2 edges after the accepting edge.
  - Range is 2 to IN_W−MAN_W+2 cycles; with defaults, 2 to 10.
- Throughput: one sample in flight. in_ready is 0 from the accepting edge until the edge after the out_ready handshake. There is no combinational in→out path.
- Backpressure: out_* must not change while out_valid=1 and out_ready=0.
- in_valid while in_ready=0 is ignored. The upstream block holds in_data until it is accepted.

## Test plan
Defaults unless noted.
1. Normal encode: in=0x1A6 (422) → sign 0, E=5, M=1101, sat 0. out_valid appears 5 cycles after accept.
2. Small and zero inputs:
   - in=0x00D → E=0, M=1101, latency 10.
   - in=0x000 → E=0, M=0000, latency 10.
3. Round carry: in=0x1F8 → E=6, M=1000, sat 0. With ROUND=0, the same input → E=5, M=1111.
4. Saturation:
   - in=0x800 → E=7, M=1111, sat 1, latency 2.
   - in=0x7F8 (rounds into E=8) → E=7, M=1111, sat 1.
5. Signed input (SIGNED=1):
   - in=0xE5A (−422) → sign 1, E=5, M=1101.
   - in=0x800 (−2048) → sign 1, saturated.
   - in=0x001 → sign 0, E=0, M=0001.
6. Handshake and reset:
   - Hold out_ready=0 for 3 cycles: outputs stay stable and in_ready stays 0. Assert out_ready: in_ready = 1 on the next cycle.
   - Pulse rst_n=0 during NORM: no out_valid appears, and all outputs read 0.
